// File: rtl/alu_issue_scheduler.sv
// Collapsing in-order-age issue queue feeding the single integer ALU.
// Entry 0 is the oldest; the oldest op with both sources ready is issued each cycle.
module alu_issue_scheduler #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [6:0]       disp_opcode,
  input  logic [2:0]       disp_func3,
  input  logic [6:0]       disp_func7,
  input  logic [TAG_W-1:0] disp_ps1,
  input  logic             disp_ps1_rdy,
  input  logic [TAG_W-1:0] disp_ps2,
  input  logic             disp_ps2_rdy,
  input  logic             disp_use_imm,
  input  logic [31:0]      disp_imm,
  input  logic [TAG_W-1:0] disp_pd,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [6:0]       iss_opcode,
  output logic [2:0]       iss_func3,
  output logic [6:0]       iss_func7,
  output logic [TAG_W-1:0] iss_ps1,
  output logic [TAG_W-1:0] iss_ps2,
  output logic             iss_use_imm,
  output logic [31:0]      iss_imm,
  output logic [TAG_W-1:0] iss_pd,
  output logic [CNT_W-1:0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [TAG_W-1:0] ps1;
    logic [TAG_W-1:0] ps2;
    logic             use_imm;
    logic [31:0]      imm;
    logic [TAG_W-1:0] pd;
  } entry_t;

  entry_t           ent   [DEPTH];
  entry_t           ent_n [DEPTH];
  logic [DEPTH-1:0] r1, r2, r1_n, r2_n;
  logic [DEPTH-1:0] valid;
  logic [CNT_W-1:0] occ_n;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             issue_fire;
  logic             disp_fire;
  entry_t           sel_ent;
  entry_t           new_ent;

  // Tag 0 is the zero register and never produces a wakeup.
  function automatic logic woken(input logic             bc_valid,
                                 input logic [TAG_W-1:0] bc_tag,
                                 input logic [TAG_W-1:0] src);
    return bc_valid && (bc_tag != '0) && (bc_tag == src);
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CNT_W'(i) < occupancy);
    end
  end

  // Descending scan so the lowest ready index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && r1[i] && r2[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign iss_valid  = sel_found && !flush;
  assign issue_fire = iss_valid && iss_ready;
  assign disp_ready = (occupancy < CNT_W'(DEPTH)) && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign wr_idx     = occupancy[IDX_W-1:0] - IDX_W'(issue_fire);

  assign new_ent = '{opcode:  disp_opcode,
                     func3:   disp_func3,
                     func7:   disp_func7,
                     ps1:     disp_ps1,
                     ps2:     disp_ps2,
                     use_imm: disp_use_imm,
                     imm:     disp_imm,
                     pd:      disp_pd};

  // Collapse above the issued slot, apply wakeup to the shifted image, then append.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = ent[i];
      r1_n[i]  = r1[i];
      r2_n[i]  = r2[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (issue_fire && (IDX_W'(i) >= sel_idx)) begin
        ent_n[i] = ent[i+1];
        r1_n[i]  = r1[i+1];
        r2_n[i]  = r2[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      r1_n[i] = r1_n[i] | woken(wb_valid, wb_tag, ent_n[i].ps1);
      r2_n[i] = r2_n[i] | woken(wb_valid, wb_tag, ent_n[i].ps2);
    end
    if (disp_fire) begin
      ent_n[wr_idx] = new_ent;
      r1_n[wr_idx]  = disp_ps1_rdy || (disp_ps1 == '0) || woken(wb_valid, wb_tag, disp_ps1);
      r2_n[wr_idx]  = disp_ps2_rdy || (disp_ps2 == '0) || woken(wb_valid, wb_tag, disp_ps2);
    end
    occ_n = occupancy + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    if (flush) begin
      occ_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
      r1        <= '0;
      r2        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      occupancy <= occ_n;
      r1        <= r1_n;
      r2        <= r2_n;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= ent_n[i];
      end
    end
  end

  // Payload is zeroed whenever nothing is presented.
  assign sel_ent     = iss_valid ? ent[sel_idx] : '0;
  assign iss_opcode  = sel_ent.opcode;
  assign iss_func3   = sel_ent.func3;
  assign iss_func7   = sel_ent.func7;
  assign iss_ps1     = sel_ent.ps1;
  assign iss_ps2     = sel_ent.ps2;
  assign iss_use_imm = sel_ent.use_imm;
  assign iss_imm     = sel_ent.imm;
  assign iss_pd      = sel_ent.pd;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed scenarios plus random traffic checked
// against a queue-based reference model; issued ops are matched through a scoreboard.
module tb_alu_issue_scheduler;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int CNT_W = 4;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [5:0]  ps1;
    logic [5:0]  ps2;
    logic        use_imm;
    logic [31:0] imm;
    logic [5:0]  pd;
  } op_t;

  typedef struct {
    op_t p;
    bit  r1;
    bit  r2;
  } mentry_t;

  typedef struct {
    bit         disp_valid;
    op_t        op;
    bit         ps1_rdy;
    bit         ps2_rdy;
    bit         wb_valid;
    logic [5:0] wb_tag;
    bit         iss_ready;
    bit         flush;
  } stim_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [6:0]       disp_opcode;
  logic [2:0]       disp_func3;
  logic [6:0]       disp_func7;
  logic [TAG_W-1:0] disp_ps1;
  logic             disp_ps1_rdy;
  logic [TAG_W-1:0] disp_ps2;
  logic             disp_ps2_rdy;
  logic             disp_use_imm;
  logic [31:0]      disp_imm;
  logic [TAG_W-1:0] disp_pd;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic             iss_valid;
  logic             iss_ready;
  logic [6:0]       iss_opcode;
  logic [2:0]       iss_func3;
  logic [6:0]       iss_func7;
  logic [TAG_W-1:0] iss_ps1;
  logic [TAG_W-1:0] iss_ps2;
  logic             iss_use_imm;
  logic [31:0]      iss_imm;
  logic [TAG_W-1:0] iss_pd;
  logic [CNT_W-1:0] occupancy;
  op_t              dut_op;

  mentry_t model_q[$];
  op_t     sb[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  alu_issue_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_func3(disp_func3), .disp_func7(disp_func7),
    .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy),
    .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_use_imm(disp_use_imm), .disp_imm(disp_imm), .disp_pd(disp_pd),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_func3(iss_func3), .iss_func7(iss_func7),
    .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_use_imm(iss_use_imm),
    .iss_imm(iss_imm), .iss_pd(iss_pd), .occupancy(occupancy)
  );

  assign dut_op = {iss_opcode, iss_func3, iss_func7, iss_ps1, iss_ps2, iss_use_imm, iss_imm, iss_pd};

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wake(input stim_t s, input logic [5:0] t);
    return s.wb_valid && (s.wb_tag != 6'd0) && (s.wb_tag == t);
  endfunction

  function automatic stim_t idle(input bit rdy);
    stim_t s;
    s.disp_valid = 1'b0;
    s.op         = '0;
    s.ps1_rdy    = 1'b0;
    s.ps2_rdy    = 1'b1;
    s.wb_valid   = 1'b0;
    s.wb_tag     = '0;
    s.iss_ready  = rdy;
    s.flush      = 1'b0;
    return s;
  endfunction

  function automatic stim_t mk_op(input logic [6:0] opc, input logic [5:0] ps1, input bit r1,
                                  input logic [5:0] ps2, input bit r2, input bit ui,
                                  input logic [31:0] imm, input logic [5:0] pd, input bit rdy);
    stim_t s;
    s = idle(rdy);
    s.disp_valid    = 1'b1;
    s.op.opcode     = opc;
    s.op.func3      = 3'($urandom);
    s.op.func7      = 7'($urandom);
    s.op.ps1        = ps1;
    s.op.ps2        = ps2;
    s.op.use_imm    = ui;
    s.op.imm        = imm;
    s.op.pd         = pd;
    s.ps1_rdy       = r1;
    s.ps2_rdy       = r2;
    return s;
  endfunction

  task automatic drive_idle();
    flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0; disp_func3 = '0; disp_func7 = '0;
    disp_ps1 = '0; disp_ps1_rdy = 1'b0; disp_ps2 = '0; disp_ps2_rdy = 1'b1;
    disp_use_imm = 1'b0; disp_imm = '0; disp_pd = '0;
    wb_valid = 1'b0; wb_tag = '0; iss_ready = 1'b0;
  endtask

  // One cycle: drive at the falling edge, then check and advance the reference model.
  task automatic apply_stimulus(input stim_t s);
    int      sel;
    bit      exp_iss, exp_dr, ifire, dfire;
    mentry_t e;
    @(negedge clk);
    flush = s.flush; disp_valid = s.disp_valid;
    disp_opcode = s.op.opcode; disp_func3 = s.op.func3; disp_func7 = s.op.func7;
    disp_ps1 = s.op.ps1; disp_ps1_rdy = s.ps1_rdy; disp_ps2 = s.op.ps2; disp_ps2_rdy = s.ps2_rdy;
    disp_use_imm = s.op.use_imm; disp_imm = s.op.imm; disp_pd = s.op.pd;
    wb_valid = s.wb_valid; wb_tag = s.wb_tag; iss_ready = s.iss_ready;
    #1;
    sel = -1;
    foreach (model_q[i]) if (sel < 0 && model_q[i].r1 && model_q[i].r2) sel = i;
    exp_iss = (sel >= 0) && !s.flush;
    exp_dr  = (model_q.size() < DEPTH) && !s.flush;
    check_output("iss_valid", 68'(iss_valid), 68'(exp_iss));
    check_output("disp_ready", 68'(disp_ready), 68'(exp_dr));
    check_output("occupancy", 68'(occupancy), 68'(model_q.size()));
    ifire = exp_iss && s.iss_ready;
    dfire = s.disp_valid && exp_dr;
    if (ifire) sb.push_back(model_q[sel].p);
    if (s.flush) begin
      model_q.delete();
    end else begin
      if (ifire) model_q.delete(sel);
      foreach (model_q[i]) begin
        if (wake(s, model_q[i].p.ps1)) model_q[i].r1 = 1'b1;
        if (wake(s, model_q[i].p.ps2)) model_q[i].r2 = 1'b1;
      end
      if (dfire) begin
        e.p  = s.op;
        e.r1 = s.ps1_rdy || (s.op.ps1 == 6'd0) || wake(s, s.op.ps1);
        e.r2 = s.ps2_rdy || (s.op.ps2 == 6'd0) || wake(s, s.op.ps2);
        model_q.push_back(e);
      end
    end
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_output("reset_iss_valid", 68'(iss_valid), 68'(0));
    check_output("reset_occupancy", 68'(occupancy), 68'(0));
    model_q.delete();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: any handshake the DUT completes must match the oldest expected issue.
  initial begin
    op_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (iss_valid && iss_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_issue: got pd %0d, expected no issue at %0t", iss_pd, $time);
          end else begin
            e = sb.pop_front();
            check_output("iss_payload", dut_op, e);
          end
        end else if (!iss_valid) begin
          check_output("iss_idle_zero", dut_op, 68'(0));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_output("por_iss_valid", 68'(iss_valid), 68'(0));
    check_output("por_occupancy", 68'(occupancy), 68'(0));
    check_output("por_payload", dut_op, 68'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ADDI with zero-register source issues the cycle after dispatch.
    apply_stimulus(mk_op(OP_IMM, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 32'd5, 6'd7, 1'b1));
    repeat (2) apply_stimulus(idle(1'b1));

    // Younger ready ADD overtakes older SUB; SUB follows its wakeup.
    apply_stimulus(mk_op(OP_REG, 6'd3, 1'b0, 6'd4, 1'b1, 1'b0, 32'd0, 6'd9, 1'b1));
    apply_stimulus(mk_op(OP_REG, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 6'd10, 1'b1));
    apply_stimulus(idle(1'b1));
    s = idle(1'b1); s.wb_valid = 1'b1; s.wb_tag = 6'd3;
    apply_stimulus(s);
    repeat (2) apply_stimulus(idle(1'b1));

    // Wakeup in the dispatch cycle is captured.
    s = mk_op(OP_REG, 6'd12, 1'b0, 6'd0, 1'b1, 1'b0, 32'd0, 6'd13, 1'b1);
    s.wb_valid = 1'b1; s.wb_tag = 6'd12;
    apply_stimulus(s);
    repeat (2) apply_stimulus(idle(1'b1));

    // Fill to full, attempt an extra dispatch, then drain in age order.
    for (int i = 0; i < DEPTH; i++)
      apply_stimulus(mk_op(OP_LD, 6'd20, 1'b0, 6'd0, 1'b1, 1'b1, 32'(i * 4), 6'(i + 1), 1'b1));
    apply_stimulus(mk_op(OP_LD, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 32'd99, 6'd40, 1'b1));
    s = idle(1'b1); s.wb_valid = 1'b1; s.wb_tag = 6'd20;
    apply_stimulus(s);
    repeat (DEPTH + 1) apply_stimulus(idle(1'b1));

    // Stall with two ready entries, then issue and dispatch together.
    apply_stimulus(mk_op(OP_REG, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'd0, 6'd21, 1'b0));
    apply_stimulus(mk_op(OP_REG, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'd0, 6'd22, 1'b0));
    repeat (3) apply_stimulus(idle(1'b0));
    apply_stimulus(mk_op(OP_IMM, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 32'hFFFF_FFF0, 6'd23, 1'b1));
    apply_stimulus(idle(1'b0));
    repeat (3) apply_stimulus(idle(1'b1));

    // Flush beats dispatch and wakeup; then reset mid-stream.
    for (int i = 0; i < 5; i++)
      apply_stimulus(mk_op(OP_REG, 6'd30, 1'b0, 6'd0, 1'b1, 1'b0, 32'd0, 6'(31 + i), 1'b1));
    s = mk_op(OP_REG, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'd0, 6'd50, 1'b1);
    s.flush = 1'b1; s.wb_valid = 1'b1; s.wb_tag = 6'd30;
    apply_stimulus(s);
    repeat (2) apply_stimulus(idle(1'b1));
    for (int i = 0; i < 3; i++)
      apply_stimulus(mk_op(OP_REG, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 32'd0, 6'(51 + i), 1'b0));
    mid_reset();
    repeat (2) apply_stimulus(idle(1'b1));

    // Random traffic over a small tag space to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      bit ui;
      ui = 1'($urandom);
      s = mk_op(7'($urandom), 6'($urandom_range(0, 7)), ($urandom % 4) == 0,
                ui ? 6'd0 : 6'($urandom_range(0, 7)), ui ? 1'b1 : (($urandom % 4) == 0),
                ui, $urandom, 6'($urandom), ($urandom % 4) != 0);
      s.disp_valid = ($urandom % 3) != 0;
      s.wb_valid   = 1'($urandom);
      s.wb_tag     = 6'($urandom_range(0, 7));
      s.flush      = ($urandom % 60) == 0;
      apply_stimulus(s);
      if (($urandom % 200) == 0) mid_reset();
    end

    for (int t = 1; t < 8; t++) begin
      s = idle(1'b1); s.wb_valid = 1'b1; s.wb_tag = 6'(t);
      apply_stimulus(s);
    end
    repeat (DEPTH + 2) apply_stimulus(idle(1'b1));
    @(negedge clk);
    #3;
    check_output("scoreboard_drained", 68'(sb.size()), 68'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
- In-order-age issue queue and scheduler feeding the single integer ALU of the out-of-order core.
- Buffers renamed ALU ops (ADD, SUB, XOR, SRA, ADDI, ANDI, LW/SW address) and tracks physical-source readiness via writeback tag broadcast.
- Each cycle, issues the oldest ready op to the ALU over a valid/ready handshake.
- Sits between rename/dispatch and the register-read/ALU stage.

Parameters:
- DEPTH, 8, queue entries; power of two, 2..16.
- TAG_W, 6, physical register tag width; matches the ALU pd width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept this cycle.
- disp_opcode  in  7  RV32 opcode.
- disp_func3  in  3  func3.
- disp_func7  in  7  func7.
- disp_ps1  in  TAG_W  physical source 1 tag.
- disp_ps1_rdy  in  1  source 1 value already available.
- disp_ps2  in  TAG_W  physical source 2 tag.
- disp_ps2_rdy  in  1  source 2 available; dispatcher drives 1 when ps2 is unused.
- disp_use_imm  in  1  ALU operand 2 is the immediate.
- disp_imm  in  32  sign-extended immediate.
- disp_pd  in  TAG_W  physical destination tag.
- wb_valid  in  1  writeback broadcast valid.
- wb_tag  in  TAG_W  tag that became ready.
- iss_valid  out  1  an op is presented to the ALU.
- iss_ready  in  1  ALU/register-read stage accepts.
- iss_opcode  out  7  selected op field.
- iss_func3  out  3  selected op field.
- iss_func7  out  7  selected op field.
- iss_ps1  out  TAG_W  selected op field.
- iss_ps2  out  TAG_W  selected op field.
- iss_use_imm  out  1  selected op field.
- iss_imm  out  32  selected op field.
- iss_pd  out  TAG_W  selected op field.
- occupancy  out  CNT_W  number of valid entries.

Behaviour:
- Reset (rst_n low, asynchronous): all entry valid bits 0, occupancy 0, iss_valid 0, all iss_* payloads 0. disp_ready is 1 once rst_n is released.
- Storage is a collapsing queue. Entry 0 is the oldest; valid entries are always contiguous 0..occupancy-1.
- Per-entry state: payload, r1, r2.
- Tag 0 is the hard-wired zero register. A source tag of 0 is treated as ready at dispatch; wb_tag==0 is ignored.
- Select (combinational from registered state): the lowest-index valid entry with r1 and r2 both set. iss_valid=1 iff such an entry exists and flush=0. iss_* reflect that entry and are 0 when iss_valid=0.
- No same-cycle wakeup-to-issue bypass: readiness for select uses registered flags only.
- Issue fires on iss_valid && iss_ready. At the clock edge the selected entry k is removed, entries k+1..occupancy-1 shift down one slot, and their flags are updated by wakeup in the same edge.
- iss_ready=0 holds the queue. The selection may change on the next cycle if an older entry becomes ready; no stickiness is required.
- Dispatch:
  - disp_ready = (occupancy < DEPTH) && !flush. Full blocks dispatch even if an issue fires the same cycle.
  - Fires on disp_valid && disp_ready. The new entry is written at index occupancy, or occupancy-1 if an issue fires the same cycle.
  - Stored flags: r1 = disp_ps1_rdy | (ps1==0) | (wb_valid && wb_tag==ps1 && wb_tag!=0); r2 computed likewise.
- Wakeup: on wb_valid with a nonzero tag, set r1/r2 in every valid entry whose ps1/ps2 equals wb_tag, including entries that are shifting. Entries already ready are unaffected.
- Latency:
  - A dispatch with ready operands at edge t can issue in the cycle following t.
  - Wakeup presented in cycle c makes the entry eligible in cycle c+1.
- Occupancy: next = occupancy + dispatch_fire − issue_fire. Simultaneous dispatch and issue leaves it unchanged.
- Flush (synchronous, highest priority over dispatch, issue and wakeup): all valid bits cleared at the edge, occupancy becomes 0, and iss_valid/disp_ready are forced 0 during the flush cycle.
- Reset asserted mid-operation discards all entries immediately, regardless of the handshakes in progress.
- The block does not interpret opcodes beyond passing them through. An op with pd==0 is issued normally.

Test Plan:
- Reset, then dispatch ADDI (ps1=0, use_imm=1, imm=5, pd=7) -> iss_valid=1 the next cycle with iss_pd=7, iss_imm=5; iss_ready=1 -> occupancy returns to 0.
- Dispatch SUB (ps1=3 not ready, ps2=4 ready, pd=9), then ADD (ps1=0, ps2=0, pd=10) -> ADD issues first. wb_tag=3 -> SUB issues one cycle later.
- Dispatch with ps1=12 not ready while wb_valid=1, wb_tag=12 in the same cycle -> entry stored ready and issues the next cycle.
- Fill 8 entries with unready ps1=20 -> disp_ready=0, occupancy=8. Attempted dispatch is ignored. wb_tag=20 -> oldest (index 0) issues each cycle in order and occupancy counts down 8..0.
- Hold iss_ready=0 for 3 cycles with 2 ready entries -> iss_* stable, occupancy unchanged. Then iss_ready=1 with a simultaneous dispatch -> occupancy stays 2 and the new entry lands at index 1.
- With 5 entries, assert flush together with disp_valid and wb_valid -> occupancy=0, iss_valid=0, nothing retained. Assert rst_n=0 mid-stream -> iss_valid drops immediately.
